// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the 5-stage MIPS core pipeline blocks.
//   - Default datapath widths.
//   - ALU operation encodings driven onto ALUOperation.
//   - Forward-select encoding used by the operand forwarding mux.
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int ALU_OP_WIDTH   = 4;
    localparam int SHAMT_WIDTH    = 5;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = 4'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = 4'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_NOR = 4'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 4'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = 4'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL = 4'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL = 4'd6;

    // Which pipeline stage supplies an operand.
    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/forward_unit.sv
// ---------------------------------------------------------------------------
// forward_unit
//   Combinational operand-forwarding mux for one source register.
//   The younger result (EX/MEM) wins over MEM/WB; register $0 is never
//   forwarded because it is hard-wired to zero in the register file.
// Ports
//   i_src_addr                     source register index held in EX
//   i_rf_data                      register-file data captured in ID
//   i_exmem_we/_dest/_result       EX/MEM write-back candidate
//   i_memwb_we/_dest/_result       MEM/WB write-back candidate
//   o_data                         forwarded operand value
// ---------------------------------------------------------------------------
module forward_unit
    import mips_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = REG_ADDR_WIDTH
) (
    input  logic [AW-1:0] i_src_addr,
    input  logic [DW-1:0] i_rf_data,
    input  logic          i_exmem_we,
    input  logic [AW-1:0] i_exmem_dest,
    input  logic [DW-1:0] i_exmem_result,
    input  logic          i_memwb_we,
    input  logic [AW-1:0] i_memwb_dest,
    input  logic [DW-1:0] i_memwb_result,
    output logic [DW-1:0] o_data
);

    fwd_sel_e w_sel;
    logic     w_src_nz;

    assign w_src_nz = (i_src_addr != '0);

    always_comb begin
        w_sel = FWD_NONE;
        if (w_src_nz && i_exmem_we && (i_exmem_dest == i_src_addr))
            w_sel = FWD_EXMEM;
        else if (w_src_nz && i_memwb_we && (i_memwb_dest == i_src_addr))
            w_sel = FWD_MEMWB;
    end

    always_comb begin
        o_data = i_rf_data;
        case (w_sel)
            FWD_EXMEM: o_data = i_exmem_result;
            FWD_MEMWB: o_data = i_memwb_result;
            default:   o_data = i_rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with operand forwarding and load-use detection.
//   Captures decoded operands/controls each cycle and drives the ALU inputs.
// Ports
//   clk, reset            clock, synchronous active-high reset
//   stall                 freeze every EX-side register
//   flush                 squash: load a bubble into EX
//   id_*                  decoded instruction fields from ID
//   exmem_*, memwb_*      write-back candidates for forwarding
//   load_use_stall        comb. request to hold PC and IF/ID
//   ex_valid, alu_*       EX-stage instruction and ALU operands
//   ex_store_data         forwarded rt for stores
//   ex_dest, ex_reg_write, ex_mem_read, ex_mem_write  EX controls
// ---------------------------------------------------------------------------
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = mips_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = mips_pkg::REG_ADDR_WIDTH,
    parameter int ALU_OP_WIDTH   = mips_pkg::ALU_OP_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [ALU_OP_WIDTH-1:0]   id_alu_op,
    input  logic [DATA_WIDTH-1:0]     id_rs_data,
    input  logic [DATA_WIDTH-1:0]     id_rt_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [SHAMT_WIDTH-1:0]    id_shamt,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
    input  logic                      id_alu_src,
    input  logic                      id_reg_dst,
    input  logic                      id_uses_rt,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      id_mem_write,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_dest,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_dest,
    input  logic [DATA_WIDTH-1:0]     memwb_result,
    output logic                      load_use_stall,
    output logic                      ex_valid,
    output logic [ALU_OP_WIDTH-1:0]   alu_operation,
    output logic [DATA_WIDTH-1:0]     alu_a,
    output logic [DATA_WIDTH-1:0]     alu_b,
    output logic [SHAMT_WIDTH-1:0]    alu_shamt,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic [REG_ADDR_WIDTH-1:0] ex_dest,
    output logic                      ex_reg_write,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write
);

    logic                      r_valid;
    logic [ALU_OP_WIDTH-1:0]   r_alu_op;
    logic [DATA_WIDTH-1:0]     r_rs_data;
    logic [DATA_WIDTH-1:0]     r_rt_data;
    logic [DATA_WIDTH-1:0]     r_imm;
    logic [SHAMT_WIDTH-1:0]    r_shamt;
    logic [REG_ADDR_WIDTH-1:0] r_rs_addr;
    logic [REG_ADDR_WIDTH-1:0] r_rt_addr;
    logic [REG_ADDR_WIDTH-1:0] r_dest;
    logic                      r_alu_src;
    logic                      r_reg_write;
    logic                      r_mem_read;
    logic                      r_mem_write;

    logic                      w_load_use;
    logic [DATA_WIDTH-1:0]     w_fwd_rs;
    logic [DATA_WIDTH-1:0]     w_fwd_rt;

    // A load in EX cannot forward its data to the very next instruction,
    // so that instruction must wait one cycle. r_mem_read is already
    // qualified by valid at capture time.
    assign w_load_use = !reset && r_valid && r_mem_read && (r_dest != '0) &&
                        ((r_dest == id_rs_addr) ||
                         (id_uses_rt && (r_dest == id_rt_addr)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_alu_op    <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_shamt     <= '0;
            r_rs_addr   <= '0;
            r_rt_addr   <= '0;
            r_dest      <= '0;
            r_alu_src   <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (stall) begin
            // Hold everything; upstream re-presents flush/hazard next time.
        end else if (flush || w_load_use) begin
            // Bubble: only valid and side-effecting controls matter, data
            // fields are left as they are.
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_valid     <= id_valid;
            r_alu_op    <= id_alu_op;
            r_rs_data   <= id_rs_data;
            r_rt_data   <= id_rt_data;
            r_imm       <= id_imm;
            r_shamt     <= id_shamt;
            r_rs_addr   <= id_rs_addr;
            r_rt_addr   <= id_rt_addr;
            r_dest      <= id_reg_dst ? id_rd_addr : id_rt_addr;
            r_alu_src   <= id_alu_src;
            r_reg_write <= id_reg_write & id_valid;
            r_mem_read  <= id_mem_read  & id_valid;
            r_mem_write <= id_mem_write & id_valid;
        end
    end

    forward_unit #(.DW(DATA_WIDTH), .AW(REG_ADDR_WIDTH)) u_fwd_rs (
        .i_src_addr     (r_rs_addr),
        .i_rf_data      (r_rs_data),
        .i_exmem_we     (exmem_reg_write),
        .i_exmem_dest   (exmem_dest),
        .i_exmem_result (exmem_result),
        .i_memwb_we     (memwb_reg_write),
        .i_memwb_dest   (memwb_dest),
        .i_memwb_result (memwb_result),
        .o_data         (w_fwd_rs)
    );

    forward_unit #(.DW(DATA_WIDTH), .AW(REG_ADDR_WIDTH)) u_fwd_rt (
        .i_src_addr     (r_rt_addr),
        .i_rf_data      (r_rt_data),
        .i_exmem_we     (exmem_reg_write),
        .i_exmem_dest   (exmem_dest),
        .i_exmem_result (exmem_result),
        .i_memwb_we     (memwb_reg_write),
        .i_memwb_dest   (memwb_dest),
        .i_memwb_result (memwb_result),
        .o_data         (w_fwd_rt)
    );

    assign load_use_stall = w_load_use;
    assign ex_valid       = r_valid;
    assign alu_operation  = r_alu_op;
    assign alu_a          = w_fwd_rs;
    assign alu_b          = r_alu_src ? r_imm : w_fwd_rt;
    assign alu_shamt      = r_shamt;
    assign ex_store_data  = w_fwd_rt;
    assign ex_dest        = r_dest;
    assign ex_reg_write   = r_reg_write;
    assign ex_mem_read    = r_mem_read;
    assign ex_mem_write   = r_mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk, reset, stall, flush, id_valid;
    logic [3:0]  id_alu_op;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt, id_rs_addr, id_rt_addr, id_rd_addr;
    logic        id_alu_src, id_reg_dst, id_uses_rt, id_reg_write, id_mem_read, id_mem_write;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_dest, memwb_dest;
    logic [31:0] exmem_result, memwb_result;
    logic        load_use_stall, ex_valid;
    logic [3:0]  alu_operation;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [4:0]  alu_shamt, ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_alu_op(id_alu_op), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt), .id_rs_addr(id_rs_addr),
        .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr), .id_alu_src(id_alu_src),
        .id_reg_dst(id_reg_dst), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_dest(memwb_dest), .memwb_result(memwb_result),
        .load_use_stall(load_use_stall), .ex_valid(ex_valid), .alu_operation(alu_operation),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .ex_store_data(ex_store_data),
        .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: what EX holds ----------------
    typedef struct {
        bit        v;
        bit [3:0]  op;
        bit [31:0] rsd, rtd, imm;
        bit [4:0]  sh, rs, rt, dst;
        bit        src, rw, mr, mw;
    } ex_t;

    ex_t m;
    bit  m_init = 0;   // model meaningful once reset seen
    bit  m_dkn  = 0;   // data fields meaningful (not a bubble)

    function automatic bit m_lus();
        if (reset || !m.v || !m.mr || m.dst == 0) return 0;
        return (m.dst == id_rs_addr) || (id_uses_rt && m.dst == id_rt_addr);
    endfunction

    // Value the ALU must see for register 'a' whose RF read was 'rf'.
    function automatic bit [31:0] m_fwd(input bit [4:0] a, input bit [31:0] rf);
        if (a == 0) return rf;
        if (exmem_reg_write && exmem_dest == a) return exmem_result;
        if (memwb_reg_write && memwb_dest == a) return memwb_result;
        return rf;
    endfunction

    always @(posedge clk) begin
        bit lus;
        lus = m_lus();
        if (reset) begin
            m = '{default: 0};
            m_init = 1;
            m_dkn = 1;
        end else if (stall) begin
            // frozen
        end else if (flush || lus) begin
            m.v = 0; m.rw = 0; m.mr = 0; m.mw = 0;
            m_dkn = 0;
        end else begin
            m.v   = id_valid;
            m.op  = id_alu_op;
            m.rsd = id_rs_data;  m.rtd = id_rt_data;  m.imm = id_imm;
            m.sh  = id_shamt;    m.rs  = id_rs_addr;  m.rt  = id_rt_addr;
            m.dst = id_reg_dst ? id_rd_addr : id_rt_addr;
            m.src = id_alu_src;
            m.rw  = id_reg_write && id_valid;
            m.mr  = id_mem_read  && id_valid;
            m.mw  = id_mem_write && id_valid;
            m_dkn = 1;
        end
    end

    // Single compare process, mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (m_init) begin
            chk("load_use_stall", {31'b0, load_use_stall}, {31'b0, m_lus()});
            chk("ex_valid",       {31'b0, ex_valid},       {31'b0, m.v});
            chk("ex_reg_write",   {31'b0, ex_reg_write},   {31'b0, m.rw});
            chk("ex_mem_read",    {31'b0, ex_mem_read},    {31'b0, m.mr});
            chk("ex_mem_write",   {31'b0, ex_mem_write},   {31'b0, m.mw});
            if (m_dkn) begin
                chk("alu_operation", {28'b0, alu_operation}, {28'b0, m.op});
                chk("alu_a",         alu_a,                  m_fwd(m.rs, m.rsd));
                chk("alu_b",         alu_b,                  m.src ? m.imm : m_fwd(m.rt, m.rtd));
                chk("alu_shamt",     {27'b0, alu_shamt},     {27'b0, m.sh});
                chk("ex_store_data", ex_store_data,          m_fwd(m.rt, m.rtd));
                chk("ex_dest",       {27'b0, ex_dest},       {27'b0, m.dst});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall = 0; flush = 0; id_valid = 0; id_alu_op = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0;
        id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
        id_alu_src = 0; id_reg_dst = 0; id_uses_rt = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        exmem_reg_write = 0; exmem_dest = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_dest = 0; memwb_result = 0;
    endtask

    initial begin
        clr();
        // 1. reset with a valid instruction presented
        reset = 1; id_valid = 1; id_alu_op = 4'd3; id_rs_data = 32'hA; id_reg_write = 1;
        id_mem_read = 1; id_rt_addr = 5'd2;
        tick(); tick();
        chk("rst ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst alu_operation", {28'b0, alu_operation}, 32'd0);
        chk("rst alu_a", alu_a, 32'd0);
        chk("rst ex_mem_read", {31'b0, ex_mem_read}, 32'd0);
        chk("rst load_use_stall", {31'b0, load_use_stall}, 32'd0);

        // 2. ADD $4 = $1(5) + $2(7)
        clr(); reset = 0;
        id_valid = 1; id_alu_op = 4'd3; id_rs_addr = 1; id_rt_addr = 2; id_rd_addr = 4;
        id_rs_data = 5; id_rt_data = 7; id_reg_dst = 1; id_uses_rt = 1; id_reg_write = 1;
        tick();
        chk("add alu_operation", {28'b0, alu_operation}, 32'd3);
        chk("add alu_a", alu_a, 32'd5);
        chk("add alu_b", alu_b, 32'd7);
        chk("add ex_dest", {27'b0, ex_dest}, 32'd4);

        // 3. forwarding priority on rs=$1 held in EX
        exmem_reg_write = 1; exmem_dest = 1; exmem_result = 100;
        memwb_reg_write = 1; memwb_dest = 1; memwb_result = 200;
        #1 chk("fwd exmem wins", alu_a, 32'd100);
        exmem_reg_write = 0;
        #1 chk("fwd memwb", alu_a, 32'd200);

        // 4. lw $3 then a reader of $3
        clr();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_alu_src = 1; id_imm = 8;
        id_rt_addr = 3; id_alu_op = 4'd3;
        tick();
        clr();
        id_valid = 1; id_alu_op = 4'd3; id_rs_addr = 3; id_rs_data = 9; id_uses_rt = 1;
        id_rd_addr = 5; id_reg_dst = 1; id_reg_write = 1;
        #1 chk("lu stall", {31'b0, load_use_stall}, 32'd1);
        tick();
        chk("lu bubble ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("lu cleared", {31'b0, load_use_stall}, 32'd0);
        memwb_reg_write = 1; memwb_dest = 3; memwb_result = 32'h55;
        tick();
        chk("lu reissue ex_valid", {31'b0, ex_valid}, 32'd1);
        chk("lu reissue alu_a", alu_a, 32'h55);

        // 5. flush, then stall freeze (flush ignored while stalled)
        clr();
        id_valid = 1; id_mem_write = 1; id_reg_write = 1; id_uses_rt = 1; flush = 1;
        tick();
        chk("flush ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("flush ex_reg_write", {31'b0, ex_reg_write}, 32'd0);
        chk("flush ex_mem_write", {31'b0, ex_mem_write}, 32'd0);
        clr();
        id_valid = 1; id_alu_op = 4'd4; id_rs_addr = 5; id_rs_data = 11;
        id_rt_addr = 6; id_rt_data = 22; id_uses_rt = 1; id_reg_write = 1;
        tick();
        stall = 1; flush = 1; id_alu_op = 4'd1; id_rs_data = 99; id_rt_data = 98;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall ex_valid", {31'b0, ex_valid}, 32'd1);
            chk("stall alu_operation", {28'b0, alu_operation}, 32'd4);
            chk("stall alu_a", alu_a, 32'd11);
            chk("stall alu_b", alu_b, 32'd22);
        end

        // 6. no forwarding from $0
        clr();
        exmem_reg_write = 1; exmem_dest = 0; exmem_result = 32'hFFFF;
        id_valid = 1; id_alu_op = 4'd3; id_rs_addr = 0; id_rs_data = 32'h1234;
        tick();
        chk("zero no fwd", alu_a, 32'h1234);

        // reset masks load_use_stall
        clr();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rt_addr = 7;
        tick();
        clr();
        id_valid = 1; id_rs_addr = 7; reset = 1;
        #1 chk("reset masks lus", {31'b0, load_use_stall}, 32'd0);
        tick();
        reset = 0;

        // randomized traffic, small register range to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            id_valid = ($urandom_range(0, 5) != 0);
            id_alu_op = 4'($urandom_range(0, 6));
            id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
            id_shamt = 5'($urandom);
            id_rs_addr = 5'($urandom_range(0, 3));
            id_rt_addr = 5'($urandom_range(0, 3));
            id_rd_addr = 5'($urandom_range(0, 3));
            id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom);
            id_uses_rt = 1'($urandom); id_reg_write = 1'($urandom);
            id_mem_read = 1'($urandom); id_mem_write = 1'($urandom);
            exmem_reg_write = 1'($urandom);
            exmem_dest = 5'($urandom_range(0, 3)); exmem_result = $urandom;
            memwb_reg_write = 1'($urandom);
            memwb_dest = 5'($urandom_range(0, 3)); memwb_result = $urandom;
            tick();
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
